// File: rtl/timer_counter.sv
// Microwave mm:ss digit-entry register and 1 Hz BCD countdown.
// Digits shift on the loadn falling edge; done pulses for one cycle after reaching 00:00.
`timescale 1ns/1ps
module timer_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data,
  input  logic       loadn,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       running,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_RUN   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_mt, r_mo, r_st, r_so;
  logic [3:0] w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
  logic [3:0] w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
  logic       r_loadn_q;
  logic       r_done, w_done_nxt;
  logic       w_accept, w_shift, w_zero, w_dec_zero;

  assign w_accept   = ~loadn & r_loadn_q;
  assign w_shift    = w_accept & (data <= 4'd9);
  assign w_zero     = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd0);
  assign w_dec_zero = (w_dec_mt == 4'd0) && (w_dec_mo == 4'd0) &&
                      (w_dec_st == 4'd0) && (w_dec_so == 4'd0);

  // BCD borrow chain; seconds wrap to 59 regardless of the entered tens value.
  always_comb begin
    w_dec_mt = r_mt;
    w_dec_mo = r_mo;
    w_dec_st = r_st;
    w_dec_so = r_so - 4'd1;
    if (r_so == 4'd0) begin
      w_dec_so = 4'd9;
      if (r_st != 4'd0) begin
        w_dec_st = r_st - 4'd1;
      end else begin
        w_dec_st = 4'd5;
        if (r_mo != 4'd0) begin
          w_dec_mo = r_mo - 4'd1;
        end else begin
          w_dec_mo = 4'd9;
          w_dec_mt = r_mt - 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mt_nxt    = r_mt;
    w_mo_nxt    = r_mo;
    w_st_nxt    = r_st;
    w_so_nxt    = r_so;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE, S_ENTRY: begin
        if (stop) begin
          if (r_state == S_ENTRY) begin
            w_state_nxt = S_IDLE;
            w_mt_nxt    = 4'd0;
            w_mo_nxt    = 4'd0;
            w_st_nxt    = 4'd0;
            w_so_nxt    = 4'd0;
          end
        end else if (start && !w_zero) begin
          w_state_nxt = S_RUN;
        end else if (w_shift) begin
          w_state_nxt = S_ENTRY;
          w_mt_nxt    = r_mo;
          w_mo_nxt    = r_st;
          w_st_nxt    = r_so;
          w_so_nxt    = data;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_PAUSE;
        end else if (tick) begin
          w_mt_nxt = w_dec_mt;
          w_mo_nxt = w_dec_mo;
          w_st_nxt = w_dec_st;
          w_so_nxt = w_dec_so;
          if (w_dec_zero) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_mt_nxt    = 4'd0;
          w_mo_nxt    = 4'd0;
          w_st_nxt    = 4'd0;
          w_so_nxt    = 4'd0;
        end else if (start && !w_zero) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_mt      <= 4'd0;
      r_mo      <= 4'd0;
      r_st      <= 4'd0;
      r_so      <= 4'd0;
      r_loadn_q <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mt      <= w_mt_nxt;
      r_mo      <= w_mo_nxt;
      r_st      <= w_st_nxt;
      r_so      <= w_so_nxt;
      r_loadn_q <= loadn;
      r_done    <= w_done_nxt;
    end
  end

  assign min_tens = r_mt;
  assign min_ones = r_mo;
  assign sec_tens = r_st;
  assign sec_ones = r_so;
  assign zero     = w_zero;
  assign running  = (r_state == S_RUN);
  assign done     = r_done;
  assign state    = r_state;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed scenarios plus random stimulus against a minutes/seconds model.
`timescale 1ns/1ps
module tb_timer_counter;

  logic       clk;
  logic       reset;
  logic [3:0] data;
  logic       loadn, tick, start, stop;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       zero, running, done;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;
  int done_count = 0;

  // Reference model: time held as plain minute and second numbers.
  int m_state, m_min, m_sec;
  bit m_prev, m_done;

  timer_counter dut (
    .clk(clk), .reset(reset), .data(data), .loadn(loadn), .tick(tick),
    .start(start), .stop(stop), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .zero(zero), .running(running),
    .done(done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_count++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic void model_reset();
    m_state = 0; m_min = 0; m_sec = 0; m_prev = 1'b1; m_done = 1'b0;
  endfunction

  function automatic void model_step(input logic [3:0] d, input logic ln, tk, st, sp);
    bit acc, z;
    acc = !ln && m_prev;
    m_prev = ln;
    z = (m_min == 0) && (m_sec == 0);
    m_done = 1'b0;
    case (m_state)
      0, 1: begin
        if (sp) begin
          if (m_state == 1) begin m_min = 0; m_sec = 0; m_state = 0; end
        end else if (st && !z) m_state = 2;
        else if (acc && d <= 4'd9) begin
          m_min = (m_min % 10) * 10 + m_sec / 10;
          m_sec = (m_sec % 10) * 10 + int'(d);
          m_state = 1;
        end
      end
      2: begin
        if (sp) m_state = 3;
        else if (tk) begin
          if (m_sec > 0) m_sec = m_sec - 1;
          else begin m_sec = 59; m_min = m_min - 1; end
          if (m_min == 0 && m_sec == 0) begin m_state = 0; m_done = 1'b1; end
        end
      end
      default: begin
        if (sp) begin m_min = 0; m_sec = 0; m_state = 0; end
        else if (st && !z) m_state = 2;
      end
    endcase
  endfunction

  function automatic logic [21:0] model_outputs();
    logic [15:0] dg;
    dg = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    return {dg, 2'(m_state), (m_min == 0 && m_sec == 0), (m_state == 2), m_done};
  endfunction

  task automatic cyc(input logic [3:0] d, input logic ln, tk, st, sp);
    data = d; loadn = ln; tick = tk; start = st; stop = sp;
    @(posedge clk);
    model_step(d, ln, tk, st, sp);
    #1;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) cyc(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic strobe(input logic [3:0] d);
    cyc(d, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(d, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic press_start(); cyc(4'd0, 1'b1, 1'b0, 1'b1, 1'b0); endtask
  task automatic press_stop();  cyc(4'd0, 1'b1, 1'b0, 1'b0, 1'b1); endtask
  task automatic do_tick();     cyc(4'd0, 1'b1, 1'b1, 1'b0, 1'b0); endtask
  task automatic go_idle();     press_stop(); press_stop(); endtask

  task automatic test_reset();
    reset = 1'b1; data = 4'd0; loadn = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000) begin
      failures++; $display("FAIL reset_digits got=%h exp=0000", {min_tens, min_ones, sec_tens, sec_ones});
    end
    checks++;
    if ({state, zero, running, done} !== 5'b00100) begin
      failures++; $display("FAIL reset_flags got=%b exp=00100", {state, zero, running, done});
    end
    reset = 1'b0;
    idle_cyc(2);
  endtask

  task automatic test_entry();
    strobe(4'd1); idle_cyc(9);
    strobe(4'd3); idle_cyc(9);
    strobe(4'd0); idle_cyc(9);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0130 || state !== 2'd1) begin
      failures++; $display("FAIL entry_0130 got=%h st=%0d exp=0130 st=1", {min_tens, min_ones, sec_tens, sec_ones}, state);
    end
    repeat (50) cyc(4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cyc(1);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h1307) begin
      failures++; $display("FAIL entry_hold got=%h exp=1307", {min_tens, min_ones, sec_tens, sec_ones});
    end
    strobe(4'd12);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h1307 || state !== 2'd1) begin
      failures++; $display("FAIL entry_bad_digit got=%h st=%0d exp=1307 st=1", {min_tens, min_ones, sec_tens, sec_ones}, state);
    end
  endtask

  task automatic test_countdown();
    int dc;
    go_idle();
    strobe(4'd1); strobe(4'd0); strobe(4'd0);
    cyc(4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0100 || running !== 1'b1) begin
      failures++; $display("FAIL start_tick got=%h run=%b exp=0100 run=1", {min_tens, min_ones, sec_tens, sec_ones}, running);
    end
    do_tick();
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0059) begin
      failures++; $display("FAIL borrow_0100 got=%h exp=0059", {min_tens, min_ones, sec_tens, sec_ones});
    end
    go_idle();
    strobe(4'd1); strobe(4'd0); strobe(4'd0); strobe(4'd0);
    press_start(); do_tick();
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0959) begin
      failures++; $display("FAIL borrow_1000 got=%h exp=0959", {min_tens, min_ones, sec_tens, sec_ones});
    end
    go_idle();
    strobe(4'd2); press_start();
    dc = done_count;
    do_tick(); do_tick();
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000 || done !== 1'b1 || state !== 2'd0) begin
      failures++; $display("FAIL done_pulse got=%h done=%b st=%0d exp=0000 done=1 st=0", {min_tens, min_ones, sec_tens, sec_ones}, done, state);
    end
    idle_cyc(3);
    checks++;
    if (done_count - dc !== 1) begin
      failures++; $display("FAIL done_width got=%0d cycles exp=1", done_count - dc);
    end
  endtask

  task automatic test_pause();
    int dc;
    go_idle();
    dc = done_count;
    strobe(4'd4); strobe(4'd5); press_start(); press_stop();
    repeat (3) do_tick();
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0045 || state !== 2'd3) begin
      failures++; $display("FAIL pause_hold got=%h st=%0d exp=0045 st=3", {min_tens, min_ones, sec_tens, sec_ones}, state);
    end
    press_start(); do_tick();
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0044 || state !== 2'd2) begin
      failures++; $display("FAIL resume got=%h st=%0d exp=0044 st=2", {min_tens, min_ones, sec_tens, sec_ones}, state);
    end
    press_stop(); press_stop();
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000 || state !== 2'd0 || done_count != dc) begin
      failures++; $display("FAIL cancel got=%h st=%0d dones=%0d exp=0000 st=0 dones=0", {min_tens, min_ones, sec_tens, sec_ones}, state, done_count - dc);
    end
  endtask

  task automatic test_priority();
    go_idle();
    strobe(4'd1); strobe(4'd0); press_start();
    cyc(4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0009 || state !== 2'd2) begin
      failures++; $display("FAIL start_tick_run got=%h st=%0d exp=0009 st=2", {min_tens, min_ones, sec_tens, sec_ones}, state);
    end
    cyc(4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0009 || state !== 2'd3) begin
      failures++; $display("FAIL stop_tick got=%h st=%0d exp=0009 st=3", {min_tens, min_ones, sec_tens, sec_ones}, state);
    end
    press_stop();
    strobe(4'd5);
    cyc(4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000 || state !== 2'd0) begin
      failures++; $display("FAIL start_stop_entry got=%h st=%0d exp=0000 st=0", {min_tens, min_ones, sec_tens, sec_ones}, state);
    end
    press_start();
    checks++;
    if (state !== 2'd0 || running !== 1'b0) begin
      failures++; $display("FAIL start_zero st=%0d run=%b exp st=0 run=0", state, running);
    end
  endtask

  task automatic test_lockout();
    go_idle();
    strobe(4'd3); press_start();
    strobe(4'd7);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0003 || state !== 2'd2) begin
      failures++; $display("FAIL lock_run got=%h st=%0d exp=0003 st=2", {min_tens, min_ones, sec_tens, sec_ones}, state);
    end
    press_stop(); strobe(4'd8);
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0003 || state !== 2'd3) begin
      failures++; $display("FAIL lock_pause got=%h st=%0d exp=0003 st=3", {min_tens, min_ones, sec_tens, sec_ones}, state);
    end
    press_stop();
    for (int i = 1; i <= 5; i++) strobe(4'(i));
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h2345 || state !== 2'd1) begin
      failures++; $display("FAIL five_digits got=%h st=%0d exp=2345 st=1", {min_tens, min_ones, sec_tens, sec_ones}, state);
    end
  endtask

  task automatic test_async_reset();
    int dc;
    go_idle();
    strobe(4'd9); press_start(); do_tick();
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0008 || running !== 1'b1) begin
      failures++; $display("FAIL pre_reset got=%h run=%b exp=0008 run=1", {min_tens, min_ones, sec_tens, sec_ones}, running);
    end
    dc = done_count;
    #3 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones, state, zero, running, done} !== {16'h0000, 5'b00100}) begin
      failures++; $display("FAIL async_reset got=%h st=%0d z=%b run=%b done=%b exp=0000 st=0 z=1 run=0 done=0",
                           {min_tens, min_ones, sec_tens, sec_ones}, state, zero, running, done);
    end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    idle_cyc(3);
    checks++;
    if (done_count != dc || state !== 2'd0) begin
      failures++; $display("FAIL reset_no_done dones=%0d st=%0d exp dones=0 st=0", done_count - dc, state);
    end
  endtask

  task automatic test_random();
    logic [3:0] d;
    logic ln, tk, st, sp;
    logic [21:0] exp, got;
    for (int i = 0; i < 3000; i++) begin
      d  = ($urandom_range(0, 99) < 85) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      ln = ($urandom_range(0, 99) >= 30);
      tk = ($urandom_range(0, 99) < 35);
      st = ($urandom_range(0, 99) < 10);
      sp = ($urandom_range(0, 99) < 4);
      cyc(d, ln, tk, st, sp);
      exp = model_outputs();
      got = {min_tens, min_ones, sec_tens, sec_ones, state, zero, running, done};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL random_cycle%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_countdown();
    test_pause();
    test_priority();
    test_lockout();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
